// File: rtl/mips_regfile_sb.sv
// mips_regfile_sb: multi-read-port register file with write bypass and pending scoreboard
//   clk, rst                     clock, async active-high reset
//   rdEn/rdAddr -> rdData/rdValid/rdBusy   NUM_RD registered read ports
//   wrEn/wrAddr/wrData           writeback, clears the pending bit
//   issEn/issAddr -> issStall    destination issue, sets the pending bit
//   pendingVec                   scoreboard flops
module mips_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rdEn,
  input  logic [NUM_RD*ADDR_W-1:0] rdAddr,
  output logic [NUM_RD*DATA_W-1:0] rdData,
  output logic [NUM_RD-1:0]        rdValid,
  output logic [NUM_RD-1:0]        rdBusy,
  input  logic                     wrEn,
  input  logic [ADDR_W-1:0]        wrAddr,
  input  logic [DATA_W-1:0]        wrData,
  input  logic                     issEn,
  input  logic [ADDR_W-1:0]        issAddr,
  output logic                     issStall,
  output logic [NUM_REGS-1:0]      pendingVec
);
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [ADDR_W-1:0]   w_ra [NUM_RD];
  logic                w_wr_ok, w_iss_ok;
  logic [NUM_REGS-1:0] w_wr_dec, w_iss_dec, w_pend_clr;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_ra
    assign w_ra[k] = rdAddr[k*ADDR_W +: ADDR_W];
  end
  // writes to a hardwired r0 are dropped entirely, so r0 is never bypassed either
  assign w_wr_ok    = wrEn & ~(ZERO_REG != 0 && wrAddr == '0);
  assign w_wr_dec   = w_wr_ok ? NUM_REGS'(1) << wrAddr : '0;
  assign w_pend_clr = pendingVec & ~w_wr_dec;
  // a write landing on the issued register this edge frees it for the new producer
  assign issStall   = issEn & pendingVec[issAddr] & ~(wrEn & (wrAddr == issAddr));
  assign w_iss_ok   = issEn & ~issStall & ~(ZERO_REG != 0 && issAddr == '0);
  assign w_iss_dec  = w_iss_ok ? NUM_REGS'(1) << issAddr : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) pendingVec <= '0;
    else pendingVec <= w_pend_clr | w_iss_dec;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    else if (w_wr_ok) r_regs[wrAddr] <= wrData;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rdData  <= '0;
      rdValid <= '0;
      rdBusy  <= '0;
    end else for (int k = 0; k < NUM_RD; k++) begin
      rdValid[k] <= rdEn[k];
      if (rdEn[k]) begin
        rdData[k*DATA_W +: DATA_W] <= (w_wr_ok && wrAddr == w_ra[k]) ? wrData : r_regs[w_ra[k]];
        rdBusy[k] <= w_pend_clr[w_ra[k]];
      end
    end
endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
Parametrised multi-read-port register file with an integrated write-pending scoreboard, for the pipelined MIPS core. Replaces the fixed 2-read/1-write RF interface: adds N read ports with registered data, write-to-read bypass, and per-register pending tracking for multi-cycle producers such as cache-miss loads. The decode stage reads operands and issues destinations here. Writeback clears pending state.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
ADDR_W, 5, register index width; must equal log2(NUM_REGS)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero and never pending

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-high reset
rdEn  input  NUM_RD  per-port read enable
rdAddr  input  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
rdData  output  NUM_RD*DATA_W  packed registered read data
rdValid  output  NUM_RD  per-port: rdData updated this cycle
rdBusy  output  NUM_RD  per-port: register was pending when read (registered with rdData)
wrEn  input  1  writeback enable
wrAddr  input  ADDR_W  writeback register
wrData  input  DATA_W  writeback value
issEn  input  1  request to mark destination pending
issAddr  input  ADDR_W  destination register being issued
issStall  output  1  combinational: issue refused this cycle
pendingVec  output  NUM_REGS  current scoreboard bits

Behaviour:
- Reset (async assert, sync-safe release): all registers 0, pendingVec 0, rdData 0, rdValid 0, rdBusy 0. The issStall output is combinational and therefore 0 while issEn=0.
- Read, 1-cycle latency: on the edge where rdEn[k]=1, rdData[k] <= value of rdAddr[k] and rdValid[k] <= 1. When rdEn[k]=0, rdValid[k] <= 0 and rdData[k] holds.
- Bypass: if wrEn=1 and wrAddr==rdAddr[k] on the same edge (and the address is not hardwired zero), rdData[k] captures wrData, not the old value. All ports bypass independently.
- rdBusy[k] <= pending bit of rdAddr[k] after this edge's writeback clear. A same-cycle write to that register gives rdBusy=0.
- Write: on the edge with wrEn=1, reg[wrAddr] <= wrData and pending[wrAddr] <= 0. A write to a non-pending register is legal (plain write).
- ZERO_REG=1: writes to r0 are dropped, reads of r0 return 0, issues to r0 are accepted but set no bit, issStall is never raised for r0.
- Issue: issStall = issEn & pending[issAddr] & ~(wrEn & wrAddr==issAddr). Issue is accepted when issEn & ~issStall; pending[issAddr] <= 1 on that edge.
- Simultaneous issue and write to the same register: the write commits data, the issue is accepted, and the pending bit ends at 1 (the new producer wins).
- Simultaneous issue and write to different registers: both bits update independently.
- A refused issue changes no state. The requester holds issEn/issAddr until accepted.
- Reset mid-operation: all pending state and data are lost immediately. rdValid drops in the same cycle as the rst assert.
- pendingVec is the registered scoreboard, directly from flops.

Test Plan:
- Reset then read all regs on port 0 and port 1 -> each rdData=0x0000_0000, rdValid=1 one cycle after rdEn, rdBusy=0.
- Write r5=0xDEAD_BEEF while port 1 reads r5 in the same cycle -> next cycle rdData[1]=0xDEAD_BEEF (bypass); port 0 reading r6 -> 0.
- Issue r7 -> pendingVec[7]=1. Issue r7 again -> issStall=1, no change. wrEn r7=0x1234 with issEn r7 same cycle -> issStall=0, reg7=0x1234, pendingVec[7] remains 1.
- Write r0=0xFFFF_FFFF, issue r0 (ZERO_REG=1) -> read r0 returns 0, pendingVec[0]=0, issStall=0.
- Issue r3, read r3 next cycle -> rdBusy=1. wrEn r3=0x55 with a concurrent read of r3 -> rdData=0x55, rdBusy=0, pendingVec[3]=0.
- Issue r9 and r10 over two cycles, assert rst mid-cycle -> pendingVec=0 and rdValid=0 immediately. After release, read r9 -> 0.
